// File: rtl/shift_issue_stage_pkg.sv
// Shared constants and types for the shift-unit issue stage.
package shift_issue_stage_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int REG_W_DEF   = 5;
  localparam int SHAMT_W_DEF = 5;
  localparam int STAGES      = 2;

  localparam logic [2:0] FN_SHLL  = 3'b000;
  localparam logic [2:0] FN_SHRL  = 3'b001;
  localparam logic [2:0] FN_SHRA  = 3'b010;
  localparam logic [2:0] FN_SHLLV = 3'b100;
  localparam logic [2:0] FN_SHRLV = 3'b101;
  localparam logic [2:0] FN_SHRAV = 3'b110;

  typedef struct packed {
    logic op1;
    logic op2;
  } sh_op_t;

  localparam sh_op_t OP_SHLL = '{op1: 1'b0, op2: 1'b0};
  localparam sh_op_t OP_SHRL = '{op1: 1'b1, op2: 1'b0};
  localparam sh_op_t OP_SHRA = '{op1: 1'b0, op2: 1'b1};
  // Both op bits set makes the external shifter return zero.
  localparam sh_op_t OP_ILL  = '{op1: 1'b1, op2: 1'b1};

  typedef struct packed {
    sh_op_t op;
    logic   use_rt;
    logic   err;
  } fdec_t;
endpackage

// File: rtl/shift_issue_stage_if.sv
// Decode, shifter and writeback signals of the shift issue stage.
interface shift_issue_stage_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int SHAMT_W = 5
);
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_funct;
  logic [DATA_W-1:0]  in_rs;
  logic [DATA_W-1:0]  in_rt;
  logic [SHAMT_W-1:0] in_shamt;
  logic [REG_W-1:0]   in_rd;
  logic [DATA_W-1:0]  sh_a;
  logic [DATA_W-1:0]  sh_amt;
  logic               sh_op1;
  logic               sh_op2;
  logic [DATA_W-1:0]  sh_res;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_res;
  logic [REG_W-1:0]   out_rd;
  logic               out_err;

  modport slave (
    input  flush, in_valid, in_funct, in_rs, in_rt, in_shamt, in_rd, sh_res, out_ready,
    output in_ready, sh_a, sh_amt, sh_op1, sh_op2, out_valid, out_res, out_rd, out_err
  );
  modport master (
    output flush, in_valid, in_funct, in_rs, in_rt, in_shamt, in_rd, sh_res, out_ready,
    input  in_ready, sh_a, sh_amt, sh_op1, sh_op2, out_valid, out_res, out_rd, out_err
  );
endinterface

// File: rtl/shift_funct_decode.sv
// Combinational funct decode into shifter op pair, amount source and illegal flag.
module shift_funct_decode
  import shift_issue_stage_pkg::*;
(
  input  logic [2:0] funct,
  output fdec_t      dec
);
  always_comb begin
    dec.op = OP_ILL;
    case (funct)
      FN_SHLL, FN_SHLLV: dec.op = OP_SHLL;
      FN_SHRL, FN_SHRLV: dec.op = OP_SHRL;
      FN_SHRA, FN_SHRAV: dec.op = OP_SHRA;
      default:           dec.op = OP_ILL;
    endcase
    dec.err    = (dec.op == OP_ILL);
    dec.use_rt = funct[2] && !dec.err;
  end
endmodule

// File: rtl/shift_issue_stage.sv
// Two-stage shift issue pipeline: S1 drives the external shifter, S2 holds the result for writeback.
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input logic                clk,
  input logic                rst,
  shift_issue_stage_if.slave bus
);
  fdec_t              dec;
  logic               adv1, adv2, acc, mv12;
  logic [DATA_W-1:0]  shamt_ext;

  logic [STAGES:1]    vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0]  a_q, a_d, amt_q, amt_d, res_q, res_d;
  sh_op_t             op_q, op_d;
  logic [REG_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic               err1_q, err1_d, err2_q, err2_d;

  shift_funct_decode u_dec (.funct(bus.in_funct), .dec(dec));

  assign shamt_ext    = DATA_W'(bus.in_shamt);
  assign adv2         = !vld_pipe_q[2] || bus.out_ready;
  assign adv1         = !vld_pipe_q[1] || adv2;
  assign bus.in_ready = adv1 && !bus.flush;
  assign acc          = bus.in_valid && bus.in_ready;
  assign mv12         = vld_pipe_q[1] && adv2;

  always_comb begin
    a_d    = a_q;
    amt_d  = amt_q;
    op_d   = op_q;
    rd1_d  = rd1_q;
    err1_d = err1_q;
    res_d  = res_q;
    rd2_d  = rd2_q;
    err2_d = err2_q;
    if (acc) begin
      a_d    = bus.in_rs;
      amt_d  = dec.use_rt ? bus.in_rt : shamt_ext;
      op_d   = dec.op;
      rd1_d  = bus.in_rd;
      err1_d = dec.err;
    end
    if (mv12) begin
      res_d  = bus.sh_res;
      rd2_d  = rd1_q;
      err2_d = err1_q;
    end
    vld_pipe_d[1] = acc  || (vld_pipe_q[1] && !adv2);
    vld_pipe_d[2] = mv12 || (vld_pipe_q[2] && !bus.out_ready);
    // Flush only kills valids; data registers are allowed to go stale.
    if (bus.flush) vld_pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      a_q        <= '0;
      amt_q      <= '0;
      op_q       <= '0;
      rd1_q      <= '0;
      err1_q     <= 1'b0;
      res_q      <= '0;
      rd2_q      <= '0;
      err2_q     <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      a_q        <= a_d;
      amt_q      <= amt_d;
      op_q       <= op_d;
      rd1_q      <= rd1_d;
      err1_q     <= err1_d;
      res_q      <= res_d;
      rd2_q      <= rd2_d;
      err2_q     <= err2_d;
    end
  end

  assign bus.sh_a      = a_q;
  assign bus.sh_amt    = amt_q;
  assign bus.sh_op1    = op_q.op1;
  assign bus.sh_op2    = op_q.op2;
  assign bus.out_valid = vld_pipe_q[2];
  assign bus.out_res   = res_q;
  assign bus.out_rd    = rd2_q;
  assign bus.out_err   = err2_q;
endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: external shifter model plus an in-order queue reference.
module tb_shift_issue_stage;
  localparam int DW = 32, RW = 5, SW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_issue_stage_if #(.DATA_W(DW), .REG_W(RW), .SHAMT_W(SW)) bus ();

  shift_issue_stage #(.DATA_W(DW), .REG_W(RW), .SHAMT_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // External shifter
  always_comb begin
    case ({bus.sh_op1, bus.sh_op2})
      2'b00:   bus.sh_res = (bus.sh_amt >= DW) ? '0 : bus.sh_a << bus.sh_amt;
      2'b10:   bus.sh_res = (bus.sh_amt >= DW) ? '0 : bus.sh_a >> bus.sh_amt;
      2'b01:   bus.sh_res = (bus.sh_amt >= DW) ? {DW{bus.sh_a[DW-1]}}
                                               : DW'($signed(bus.sh_a) >>> bus.sh_amt);
      default: bus.sh_res = '0;
    endcase
  end

  typedef struct {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          err;
    logic [DW-1:0] a;
    logic [DW-1:0] amt;
    bit            in_s2;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t ref_ent(logic [2:0] fn, logic [DW-1:0] rs, logic [DW-1:0] rt,
                                   logic [SW-1:0] sh, logic [RW-1:0] rd);
    ent_t e;
    longint unsigned amt;
    amt     = fn[2] ? longint'(rt) : longint'(sh);
    e.a     = rs;
    e.amt   = amt[DW-1:0];
    e.rd    = rd;
    e.err   = (fn[1:0] == 2'b11);
    e.in_s2 = 1'b0;
    e.res   = '0;
    if (!e.err) begin
      case (fn[1:0])
        2'b00: e.res = (amt >= DW) ? '0 : DW'(rs * (64'd1 << amt));
        2'b01: e.res = (amt >= DW) ? '0 : DW'(rs / (64'd1 << amt));
        default: begin
          e.res = rs;
          for (longint i = 0; i < amt && i < DW; i++) e.res = {e.res[DW-1], e.res[DW-1:1]};
        end
      endcase
    end
    return e;
  endfunction

  task automatic step(bit r, bit v, bit fl, bit ordy, logic [2:0] fn, logic [DW-1:0] rs,
                      logic [DW-1:0] rt, logic [SW-1:0] sh, logic [RW-1:0] rd);
    bit   ev, rdy;
    ent_t t;
    rst = r; bus.flush = fl; bus.in_valid = v; bus.in_funct = fn; bus.in_rs = rs;
    bus.in_rt = rt; bus.in_shamt = sh; bus.in_rd = rd; bus.out_ready = ordy;
    #1;
    ev  = mq.size() > 0 && mq[0].in_s2;
    rdy = !fl && (mq.size() < 2 || ordy);
    if (!r) begin
      chk("in_ready", bus.in_ready, rdy);
      chk("out_valid", bus.out_valid, ev);
      if (ev) begin
        chk("out_res", bus.out_res, mq[0].res);
        chk("out_rd", bus.out_rd, mq[0].rd);
        chk("out_err", bus.out_err, mq[0].err);
      end
      if (mq.size() > 0 && !mq[mq.size()-1].in_s2) begin
        chk("sh_a", bus.sh_a, mq[mq.size()-1].a);
        if (!mq[mq.size()-1].err) chk("sh_amt", bus.sh_amt, mq[mq.size()-1].amt);
      end
    end
    @(posedge clk);
    if (r) mq.delete();
    else begin
      if (ev && ordy) void'(mq.pop_front());
      if (fl) mq.delete();
      else begin
        if (mq.size() > 0 && !mq[0].in_s2) begin
          t = mq[0]; t.in_s2 = 1'b1; mq[0] = t;
        end
        if (v && rdy) mq.push_back(ref_ent(fn, rs, rt, sh, rd));
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(int n, bit ordy);
    for (int i = 0; i < n; i++) step(0, 0, 0, ordy, 3'b000, '0, '0, '0, '0);
  endtask

  task automatic rst_chk();
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_sh_op1", bus.sh_op1, 0);
    chk("rst_sh_op2", bus.sh_op2, 0);
    chk("rst_sh_a", bus.sh_a, 0);
    chk("rst_sh_amt", bus.sh_amt, 0);
    chk("rst_out_res", bus.out_res, 0);
    chk("rst_out_rd", bus.out_rd, 0);
    chk("rst_out_err", bus.out_err, 0);
  endtask

  initial begin
    rst = 1'b1; bus.flush = 0; bus.in_valid = 0; bus.in_funct = '0; bus.in_rs = '0;
    bus.in_rt = '0; bus.in_shamt = '0; bus.in_rd = '0; bus.out_ready = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 3'b000, '0, '0, '0, '0);
    step(1, 0, 0, 0, 3'b000, '0, '0, '0, '0);
    rst = 1'b0;
    rst_chk();

    // basic ops back to back
    step(0, 1, 0, 1, 3'b000, 32'h0000_0001, '0, 5'd4, 5'd3);
    step(0, 1, 0, 1, 3'b010, 32'h8000_0000, '0, 5'd4, 5'd4);
    idle(3, 1);

    // oversize variable amounts
    step(0, 1, 0, 1, 3'b101, 32'hFFFF_FFFF, 32'd40, 5'd0, 5'd8);
    step(0, 1, 0, 1, 3'b110, 32'h8000_0000, 32'd40, 5'd0, 5'd9);
    idle(3, 1);

    // illegal then legal
    step(0, 1, 0, 1, 3'b011, 32'h1234_5678, '0, 5'd2, 5'd10);
    step(0, 1, 0, 1, 3'b001, 32'h1234_5678, '0, 5'd4, 5'd11);
    idle(3, 1);

    // backpressure
    step(0, 1, 0, 0, 3'b000, 32'h1, '0, 5'd1, 5'd1);
    step(0, 1, 0, 0, 3'b000, 32'h2, '0, 5'd1, 5'd2);
    step(0, 1, 0, 0, 3'b000, 32'h3, '0, 5'd1, 5'd3);
    step(0, 1, 0, 0, 3'b000, 32'h3, '0, 5'd1, 5'd3);
    step(0, 1, 0, 1, 3'b000, 32'h3, '0, 5'd1, 5'd3);
    idle(4, 1);

    // flush with both stages full and a pending input
    step(0, 1, 0, 0, 3'b001, 32'h50, '0, 5'd1, 5'd5);
    step(0, 1, 0, 0, 3'b001, 32'h60, '0, 5'd1, 5'd6);
    step(0, 1, 1, 0, 3'b001, 32'h70, '0, 5'd1, 5'd7);
    idle(3, 1);

    // reset mid-stream
    step(0, 1, 0, 0, 3'b100, 32'hABCD, 32'd3, 5'd0, 5'd12);
    step(0, 1, 0, 0, 3'b010, 32'hF000_0000, '0, 5'd8, 5'd13);
    step(1, 0, 0, 0, 3'b000, '0, '0, '0, '0);
    rst = 1'b0;
    rst_chk();
    idle(1, 1);

    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] rt;
      rt = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 40));
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)), DW'($urandom), rt, SW'($urandom), RW'($urandom));
    end
    idle(4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
